// File: rtl/sdram_ch2_bridge_if.sv
// sdram_ch2_bridge_if: host strobe/ack bus plus ch2 slot handshake of the SDRAM channel-2 bridge
interface sdram_ch2_bridge_if;
  logic [19:0] host_addr;
  logic [31:0] host_din;
  logic [3:0]  host_be;
  logic        host_req;
  logic        host_busy;
  logic        host_ack;
  logic        host_err;
  logic [31:0] host_dout;
  logic [20:0] ch2addr;
  logic [15:0] ch2din;
  logic [1:0]  ch2wr;
  logic        ch2rd;
  logic [31:0] ch2dout;
  logic        ch2ardy;
  logic        ch2drdy;
  modport slave (
    input  host_addr, host_din, host_be, host_req, ch2dout, ch2ardy, ch2drdy,
    output host_busy, host_ack, host_err, host_dout, ch2addr, ch2din, ch2wr, ch2rd
  );
  modport master (
    output host_addr, host_din, host_be, host_req, ch2dout, ch2ardy, ch2drdy,
    input  host_busy, host_ack, host_err, host_dout, ch2addr, ch2din, ch2wr, ch2rd
  );
endinterface

// File: rtl/sdram_ch2_bridge.sv
// sdram_ch2_bridge: 32-bit host strobe/ack to SDRAM ch2 slot handshake with watchdog; SDRAM_CH2_RDCACHE_EN adds a one-entry read cache
module sdram_ch2_bridge #(
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  sdram_ch2_bridge_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT_A = 3'd2;
  localparam logic [2:0] WAIT_D = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  logic [2:0]  state;
  logic [19:0] a_q;
  logic [31:0] d_q;
  logic [3:0]  be_q;
  logic        wr_q;
  logic        lo_pend;
  logic [7:0]  cnt;
  logic        drdy_q;
  logic        rise;
  logic        wd_exp;
  logic        abort;
  logic        hit;
  logic [31:0] hit_data;
  assign rise   = bus.ch2drdy & ~drdy_q;
  assign wd_exp = cnt == 8'(TIMEOUT - 1);
  assign abort  = wd_exp && ((state == WAIT_A && !bus.ch2ardy) || (state == WAIT_D && !rise));
`ifdef SDRAM_CH2_RDCACHE_EN
  logic        c_valid;
  logic [19:0] c_tag;
  logic [31:0] c_data;
  assign hit      = c_valid && c_tag == bus.host_addr;
  assign hit_data = c_data;
  // single-entry cache: filled by a completed read, dropped by a write to its word or an abort
  always_ff @(posedge clk) begin
    if (rst) c_valid <= 1'b0;
    else if (state == IDLE && bus.host_req && |bus.host_be && bus.host_addr == c_tag) c_valid <= 1'b0;
    else if (state == WAIT_D && rise && !wr_q) begin
      c_valid <= 1'b1;
      c_tag   <= a_q;
      c_data  <= bus.ch2dout;
    end
    else if (abort) c_valid <= 1'b0;
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif
  // transaction sequencer: accept, issue halves, await ardy then drdy edge, complete or abort
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      drdy_q        <= 1'b0;
      lo_pend       <= 1'b0;
      bus.host_busy <= 1'b0;
      bus.host_ack  <= 1'b0;
      bus.host_err  <= 1'b0;
      bus.host_dout <= '0;
      bus.ch2addr   <= '0;
      bus.ch2din    <= '0;
      bus.ch2wr     <= '0;
      bus.ch2rd     <= 1'b0;
    end else begin
      drdy_q       <= bus.ch2drdy;
      bus.host_ack <= 1'b0;
      bus.host_err <= 1'b0;
      case (state)
        IDLE: if (bus.host_req) begin
          a_q           <= bus.host_addr;
          d_q           <= bus.host_din;
          be_q          <= bus.host_be;
          wr_q          <= |bus.host_be;
          cnt           <= '0;
          bus.host_busy <= 1'b1;
          if (bus.host_be == 4'b0000) begin
            if (hit) state <= ISSUE;
            else begin
              bus.ch2rd   <= 1'b1;
              bus.ch2addr <= {bus.host_addr, 1'b0};
              state       <= WAIT_A;
            end
          end else if (|bus.host_be[3:2]) begin
            bus.ch2addr <= {bus.host_addr, 1'b0};
            bus.ch2din  <= bus.host_din[31:16];
            bus.ch2wr   <= bus.host_be[3:2];
            lo_pend     <= |bus.host_be[1:0];
            state       <= WAIT_A;
          end else begin
            bus.ch2addr <= {bus.host_addr, 1'b1};
            bus.ch2din  <= bus.host_din[15:0];
            bus.ch2wr   <= bus.host_be[1:0];
            lo_pend     <= 1'b0;
            state       <= WAIT_A;
          end
        end
        ISSUE: begin
          bus.host_dout <= hit_data;
          bus.host_ack  <= 1'b1;
          bus.host_busy <= 1'b0;
          state         <= DONE;
        end
        WAIT_A: if (bus.ch2ardy) begin
          bus.ch2rd <= 1'b0;
          bus.ch2wr <= '0;
          cnt       <= '0;
          state     <= WAIT_D;
        end else if (abort) begin
          bus.ch2rd     <= 1'b0;
          bus.ch2wr     <= '0;
          bus.host_ack  <= 1'b1;
          bus.host_err  <= 1'b1;
          bus.host_busy <= 1'b0;
          state         <= IDLE;
        end else cnt <= cnt + 8'd1;
        WAIT_D: if (rise) begin
          if (wr_q && lo_pend) begin
            bus.ch2addr <= {a_q, 1'b1};
            bus.ch2din  <= d_q[15:0];
            bus.ch2wr   <= be_q[1:0];
            lo_pend     <= 1'b0;
            cnt         <= '0;
            state       <= WAIT_A;
          end else begin
            bus.host_dout <= wr_q ? bus.host_dout : bus.ch2dout;
            bus.host_ack  <= 1'b1;
            bus.host_busy <= 1'b0;
            state         <= DONE;
          end
        end else if (abort) begin
          bus.host_ack  <= 1'b1;
          bus.host_err  <= 1'b1;
          bus.host_busy <= 1'b0;
          state         <= IDLE;
        end else cnt <= cnt + 8'd1;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_ch2_bridge.sv
// tb_sdram_ch2_bridge: randomized host traffic against a word-level memory/cache reference model
module tb_sdram_ch2_bridge;
  logic clk;
  logic rst;
  sdram_ch2_bridge_if bus();
  sdram_ch2_bridge #(.TIMEOUT(255)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic        noardy = 1'b0;
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];
  logic [15:0] ctl_mem[logic [20:0]];
  logic [31:0] ref_mem[logic [19:0]];
  logic        ref_cv = 1'b0;
  logic [19:0] ref_ct = '0;
  logic [31:0] last_rd = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] dflt(input logic [20:0] x);
    return x[15:0] ^ 16'hA5C3;
  endfunction
  function automatic logic [15:0] hw_rd(input logic [20:0] x);
    return ctl_mem.exists(x) ? ctl_mem[x] : dflt(x);
  endfunction
  function automatic logic [31:0] ref_word(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : {dflt({a, 1'b0}), dflt({a, 1'b1})};
  endfunction
  task automatic cmp_log();
    chk("ch2_count", 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) chk("ch2_req", 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask
  // controller model: random slot delay, ardy pulse, then a multi-cycle drdy level
  initial begin
    logic [39:0] r;
    logic [15:0] h;
    int k;
    bus.ch2ardy = 1'b0;
    bus.ch2drdy = 1'b0;
    bus.ch2dout = '0;
    forever begin
      @(posedge clk); #1;
      if (!noardy && !rst && (bus.ch2rd || bus.ch2wr != 2'b00)) begin
        k = $urandom_range(0, 4);
        repeat (k) begin @(posedge clk); #1; end
        r = {bus.ch2rd, bus.ch2wr, bus.ch2addr, bus.ch2rd ? 16'h0 : bus.ch2din};
        obs_q.push_back(r);
        if (!bus.ch2rd) begin
          h = hw_rd(bus.ch2addr);
          if (bus.ch2wr[1]) h[15:8] = bus.ch2din[15:8];
          if (bus.ch2wr[0]) h[7:0] = bus.ch2din[7:0];
          ctl_mem[bus.ch2addr] = h;
        end
        bus.ch2ardy = 1'b1;
        @(posedge clk); #1;
        bus.ch2ardy = 1'b0;
        k = $urandom_range(1, 6);
        repeat (k) begin @(posedge clk); #1; end
        bus.ch2dout = r[39] ? {hw_rd({r[35:17], 1'b0} >> 0 == 0 ? {r[35:16]} : {r[35:16]}), 16'h0} : $urandom;
        if (r[39]) bus.ch2dout = {hw_rd({r[35:17], 2'b00} >> 1), hw_rd(({r[35:17], 2'b00} >> 1) | 21'd1)};
        bus.ch2drdy = 1'b1;
        k = $urandom_range(2, 4);
        repeat (k) begin @(posedge clk); #1; end
        bus.ch2drdy = 1'b0;
      end
    end
  end
  task automatic txn(input logic [19:0] a, input logic [3:0] be, input logic [31:0] d);
    int n;
    logic hit;
    logic [31:0] w;
    hit = be == 4'b0000 && ref_cv && ref_ct == a;
    if (be == 4'b0000) begin
      if (!hit) exp_q.push_back({1'b1, 2'b00, a, 1'b0, 16'h0});
    end else begin
      if (|be[3:2]) exp_q.push_back({1'b0, be[3:2], a, 1'b0, d[31:16]});
      if (|be[1:0]) exp_q.push_back({1'b0, be[1:0], a, 1'b1, d[15:0]});
    end
    @(negedge clk);
    bus.host_addr = a;
    bus.host_be   = be;
    bus.host_din  = d;
    bus.host_req  = 1'b1;
    @(posedge clk); #1;
    bus.host_req = 1'b0;
    chk("busy_after_req", bus.host_busy, 1);
    n = 0;
    while (!bus.host_ack && n < 600) begin @(posedge clk); #1; n++; end
    chk("ack_seen", bus.host_ack, 1);
    chk("err_clear", bus.host_err, 0);
    chk("busy_at_ack", bus.host_busy, 0);
    if (hit) chk("hit_latency", 64'(n), 64'd1);
    if (be == 4'b0000) begin
      chk("rd_data", bus.host_dout, ref_word(a));
      last_rd = ref_word(a);
`ifdef SDRAM_CH2_RDCACHE_EN
      ref_cv = 1'b1;
      ref_ct = a;
`endif
    end else begin
      w = ref_word(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[a] = w;
      if (ref_ct == a) ref_cv = 1'b0;
    end
    @(posedge clk); #1;
    chk("ack_pulse", bus.host_ack, 0);
    cmp_log();
  endtask
  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int n;
    int acks;
    rst = 1'b1;
    bus.host_req  = 1'b0;
    bus.host_addr = '0;
    bus.host_din  = '0;
    bus.host_be   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.host_busy, 0);
    chk("rst_ack", bus.host_ack, 0);
    chk("rst_err", bus.host_err, 0);
    chk("rst_dout", bus.host_dout, 0);
    chk("rst_ch2rd", bus.ch2rd, 0);
    chk("rst_ch2wr", bus.ch2wr, 0);
    chk("rst_ch2addr", bus.ch2addr, 0);
    chk("rst_ch2din", bus.ch2din, 0);
    @(negedge clk);
    rst = 1'b0;
    ctl_mem[21'h024688] = 16'hDEAD;
    ctl_mem[21'h024689] = 16'hBEEF;
    ref_mem[20'h12344]  = 32'hDEADBEEF;
    txn(20'h12344, 4'b0000, 32'h0);
    txn(20'h00200, 4'b1111, 32'hAABBCCDD);
    txn(20'h00201, 4'b0010, 32'h11223344);
    txn(20'h00202, 4'b1000, 32'h55667788);
    txn(20'h00200, 4'b0000, 32'h0);
    txn(20'h00201, 4'b0000, 32'h0);
    txn(20'h00202, 4'b0000, 32'h0);
    txn(20'h00300, 4'b0000, 32'h0);
    txn(20'h00300, 4'b0000, 32'h0);
    txn(20'h00300, 4'b0100, 32'h00990000);
    txn(20'h00300, 4'b0000, 32'h0);
    noardy = 1'b1;
    @(negedge clk);
    bus.host_addr = 20'h70000;
    bus.host_be   = 4'b0000;
    bus.host_req  = 1'b1;
    @(posedge clk); #1;
    bus.host_req = 1'b0;
    n = 0;
    while (!bus.host_ack && n < 600) begin @(posedge clk); #1; n++; end
    chk("to_latency", 64'(n), 64'd255);
    chk("to_err", bus.host_err, 1);
    chk("to_dout", bus.host_dout, last_rd);
    @(posedge clk); #1;
    chk("to_rd_low", bus.ch2rd, 0);
    chk("to_ack_pulse", bus.host_ack, 0);
    noardy = 1'b0;
    ref_cv = 1'b0;
    txn(20'h70001, 4'b0000, 32'h0);
    exp_q.push_back({1'b1, 2'b00, 20'h70010, 1'b0, 16'h0});
    @(negedge clk);
    bus.host_addr = 20'h70010;
    bus.host_be   = 4'b0000;
    bus.host_req  = 1'b1;
    @(posedge clk); #1;
    bus.host_req = 1'b0;
    n = 0;
    while (bus.ch2rd && n < 100) begin @(posedge clk); #1; n++; end
    chk("rst_reach_wait_d", 64'(n < 100), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", bus.host_busy, 0);
    chk("midrst_ch2rd", bus.ch2rd, 0);
    chk("midrst_ch2wr", bus.ch2wr, 0);
    chk("midrst_ack", bus.host_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    ref_cv = 1'b0;
    acks = 0;
    repeat (20) begin @(posedge clk); #1; acks += int'(bus.host_ack); end
    chk("midrst_no_ack", 64'(acks), 64'd0);
    cmp_log();
    for (int i = 0; i < 150; i++) begin
      logic [3:0] be;
      be = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      txn(20'h00100 + 20'($urandom_range(0, 7)), be, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
